// File: rtl/ac97_pkg.sv
// ac97_pkg: shared AC'97 link constants, slot/tag bit positions and the
// receive-side state type. Imported by the receive deserializer and its
// slot shifter.
package ac97_pkg;

  localparam int AC97_TAG_BITS   = 16;
  localparam int AC97_SLOT_BITS  = 20;
  localparam int AC97_NUM_SLOTS  = 12;
  localparam int AC97_FRAME_BITS = 256;

  // Frame-relative bit index of the last bit of the tag and of slots 1..4.
  localparam logic [7:0] TAG_END   = 8'd15;
  localparam logic [7:0] SLOT1_END = 8'd35;
  localparam logic [7:0] SLOT2_END = 8'd55;
  localparam logic [7:0] SLOT3_END = 8'd75;
  localparam logic [7:0] SLOT4_END = 8'd95;
  localparam logic [7:0] LAST_BIT  = 8'(AC97_FRAME_BITS - 1);

  // Bit positions inside the 16-bit tag word.
  localparam int TAG_READY  = 15;
  localparam int TAG_SLOT1  = 14;
  localparam int TAG_SLOT2  = 13;
  localparam int TAG_SLOT3  = 12;
  localparam int TAG_SLOT4  = 11;
  localparam int TAG_VLD_LO = 3;   // slot 12 valid bit

  typedef enum logic {
    RX_HUNT = 1'b0,
    RX_RUN  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ac97_slot_shifter.sv
// ac97_slot_shifter: MSB-first serial-to-parallel shifter.
// Keeps the last WIDTH-1 received bits; word_o presents them together with
// the bit arriving on this edge, so a full slot word is available on the
// same edge its final bit is sampled.
//   clk_i      - bit clock
//   rst_i      - synchronous active-high reset
//   shift_en_i - shift sdata_i in on this edge
//   sdata_i    - serial input, MSB first
//   word_o     - {history, sdata_i}, newest bit in the LSB
module ac97_slot_shifter
  import ac97_pkg::*;
#(
  parameter int WIDTH = AC97_SLOT_BITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-2:0] hist_q, hist_d;

  assign word_o = {hist_q, sdata_i};

  always_comb begin
    hist_d = hist_q;
    if (shift_en_i) hist_d = word_o[WIDTH-2:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= '0;
    else       hist_q <= hist_d;
  end

endmodule

// File: rtl/ac97_rx_frame.sv
// ac97_rx_frame: AC'97 receive-side frame deserializer.
// Aligns to frames using the locally generated SYNC, extracts the tag,
// status address/data (slots 1/2) and capture PCM (slots 3/4), and commits
// them to registered outputs the cycle after the last bit of each frame.
//   ac97_bit_clock - bit clock, rising edge only
//   reset          - synchronous active-high
//   ac97_synch     - observed SYNC
//   ac97_sdata_in  - codec serial data, MSB first
//   codec_ready / slot_valid - tag of last complete frame
//   status_addr / status_data / status_valid - codec register readback
//   pcm_left / pcm_right / pcm_valid         - capture sample pair
//   frame_done - pulse per complete frame; sync_error - pulse per aborted frame
module ac97_rx_frame
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH = 20
) (
  input  logic                 ac97_bit_clock,
  input  logic                 reset,
  input  logic                 ac97_synch,
  input  logic                 ac97_sdata_in,
  output logic                 codec_ready,
  output logic [11:0]          slot_valid,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic                 status_valid,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 pcm_valid,
  output logic                 frame_done,
  output logic                 sync_error
);

  rx_state_e state_q, state_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic       sync_q;
  logic       sync_rise;
  logic       shift_en, commit, abort;
  logic [AC97_SLOT_BITS-1:0] word;

  // Holding registers for the frame in flight.
  logic [15:0]          tag_q;
  logic [6:0]           addr_hold_q;
  logic [15:0]          data_hold_q;
  logic [PCM_WIDTH-1:0] left_hold_q, right_hold_q;

  // Output registers.
  logic                 codec_ready_q, status_valid_q, pcm_valid_q;
  logic                 frame_done_q, sync_error_q;
  logic [11:0]          slot_valid_q;
  logic [6:0]           status_addr_q;
  logic [15:0]          status_data_q;
  logic [PCM_WIDTH-1:0] pcm_left_q, pcm_right_q;

  logic ld_status, ld_pcm;

  assign sync_rise = ac97_synch & ~sync_q;

  ac97_slot_shifter #(.WIDTH(AC97_SLOT_BITS)) u_shift (
    .clk_i      (ac97_bit_clock),
    .rst_i      (reset),
    .shift_en_i (shift_en),
    .sdata_i    (ac97_sdata_in),
    .word_o     (word)
  );

  // Frame sequencing. The bit-255 edge takes priority over the misplaced
  // SYNC check: a rise there is the normal start of the next frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    commit    = 1'b0;
    abort     = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      RX_HUNT: begin
        bit_cnt_d = '0;
        if (sync_rise) state_d = RX_RUN;
      end
      RX_RUN: begin
        if (bit_cnt_q == LAST_BIT) begin
          commit    = 1'b1;
          shift_en  = 1'b1;
          bit_cnt_d = '0;
          state_d   = sync_rise ? RX_RUN : RX_HUNT;
        end else if (sync_rise) begin
          // Data on the aborting edge is dropped; the next edge is bit 0.
          abort     = 1'b1;
          bit_cnt_d = '0;
        end else begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      default: state_d = RX_HUNT;
    endcase
  end

  // Status and PCM pulses are suppressed whenever the codec is not ready.
  assign ld_status = commit & tag_q[TAG_READY] & tag_q[TAG_SLOT1] & tag_q[TAG_SLOT2];
  assign ld_pcm    = commit & tag_q[TAG_READY] & (tag_q[TAG_SLOT3] | tag_q[TAG_SLOT4]);

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      state_q   <= RX_HUNT;
      bit_cnt_q <= '0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sync_q    <= ac97_synch;
    end
  end

  always_ff @(posedge ac97_bit_clock) begin
    if (reset || abort) begin
      tag_q        <= '0;
      addr_hold_q  <= '0;
      data_hold_q  <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
    end else if (shift_en) begin
      if (bit_cnt_q == TAG_END)   tag_q        <= word[15:0];
      if (bit_cnt_q == SLOT1_END) addr_hold_q  <= word[18:12];
      if (bit_cnt_q == SLOT2_END) data_hold_q  <= word[19:4];
      if (bit_cnt_q == SLOT3_END) left_hold_q  <= word[AC97_SLOT_BITS-1 -: PCM_WIDTH];
      if (bit_cnt_q == SLOT4_END) right_hold_q <= word[AC97_SLOT_BITS-1 -: PCM_WIDTH];
    end
  end

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      codec_ready_q  <= 1'b0;
      slot_valid_q   <= '0;
      status_addr_q  <= '0;
      status_data_q  <= '0;
      status_valid_q <= 1'b0;
      pcm_left_q     <= '0;
      pcm_right_q    <= '0;
      pcm_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      sync_error_q   <= 1'b0;
    end else begin
      frame_done_q   <= commit;
      sync_error_q   <= abort;
      status_valid_q <= ld_status;
      pcm_valid_q    <= ld_pcm;
      if (commit) begin
        codec_ready_q <= tag_q[TAG_READY];
        slot_valid_q  <= tag_q[TAG_SLOT1:TAG_VLD_LO];
      end
      if (ld_status) begin
        status_addr_q <= addr_hold_q;
        status_data_q <= data_hold_q;
      end
      if (ld_pcm) begin
        // A channel whose slot is not tagged valid reads as silence.
        pcm_left_q  <= tag_q[TAG_SLOT3] ? left_hold_q  : '0;
        pcm_right_q <= tag_q[TAG_SLOT4] ? right_hold_q : '0;
      end
    end
  end

  assign codec_ready  = codec_ready_q;
  assign slot_valid   = slot_valid_q;
  assign status_addr  = status_addr_q;
  assign status_data  = status_data_q;
  assign status_valid = status_valid_q;
  assign pcm_left     = pcm_left_q;
  assign pcm_right    = pcm_right_q;
  assign pcm_valid    = pcm_valid_q;
  assign frame_done   = frame_done_q;
  assign sync_error   = sync_error_q;

endmodule
